// File: rtl/fifo_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : fifo_pkg                                                   |
// | Description : Definitions shared by the shift-register FIFO and its read |
// |               side serial transmitter: default word width, the state     |
// |               encoding of the transmitter FSM and a frame-length helper. |
// |               The PARITY state is used only in builds that define        |
// |               FIFO_SERIAL_TX_PARITY_EN.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

   // Word width shared between the FIFO and its consumers.
   localparam int unsigned c_fifo_data_width = 8;

   // Transmitter state encoding (3-bit, legacy-compatible constants).
   typedef logic [2:0] fifo_state_t;

   localparam fifo_state_t c_st_idle   = 3'd0;
   localparam fifo_state_t c_st_req    = 3'd1;
   localparam fifo_state_t c_st_wait   = 3'd2;
   localparam fifo_state_t c_st_start  = 3'd3;
   localparam fifo_state_t c_st_data   = 3'd4;
   localparam fifo_state_t c_st_parity = 3'd5;
   localparam fifo_state_t c_st_stop   = 3'd6;
   localparam fifo_state_t c_st_gap    = 3'd7;

   // Number of serial bits in one frame: start + data + (parity) + stop.
   function automatic int unsigned frame_bits(input int unsigned data_width,
                                              input bit          parity_en);
      return data_width + (parity_en ? 32'd3 : 32'd2);
   endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/bit_timer.sv
// +--------------------------------------------------------------------------+
// | Module      : bit_timer                                                  |
// | Description : Serial bit-period timer. A down-counter that is loaded     |
// |               with CLKS_PER_BIT-1 and, while enabled, pulses tick on the |
// |               last clock of each bit period and reloads itself, so       |
// |               consecutive bits need no further load.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk     in  1  clock, all state on posedge                             |
// |   reset_n in  1  asynchronous active-low reset (counter cleared to 0)    |
// |   load    in  1  start a new bit period on the next clock                |
// |   enable  in  1  count while high                                        |
// |   tick    out 1  high during the final clock of a bit period             |
// +--------------------------------------------------------------------------+
`default_nettype none

module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic enable,
   output logic tick
);

   localparam int                 c_cnt_w  = $clog2(CLKS_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(CLKS_PER_BIT - 1);

   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= c_reload;
      end else if (enable) begin
         if (r_count == '0) begin
            r_count <= c_reload;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // A load in the same cycle restarts the period, so it masks the tick.
   assign tick = enable && !load && (r_count == '0);

endmodule : bit_timer

`default_nettype wire

// File: rtl/fifo_serial_tx.sv
// +--------------------------------------------------------------------------+
// | Module      : fifo_serial_tx                                             |
// | Description : Read-side consumer of the shift-register FIFO. Pops one    |
// |               word per frame through the rd_en/rd_data/rd_val interface  |
// |               and shifts it out as a UART-style frame: start bit (0),    |
// |               data LSB first, optional even parity, stop bit (1).        |
// |               An empty read backs off for POLL_GAP cycles before polling |
// |               again. Optional feature macro: FIFO_SERIAL_TX_PARITY_EN    |
// |               inserts an even-parity bit between data and stop.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in  1           clock, all state on posedge               |
// |   reset_n      in  1           asynchronous active-low reset             |
// |   tx_en        in  1           level enable for issuing new reads        |
// |   fifo_rd_en   out 1           one-cycle read pulse to the FIFO          |
// |   fifo_rd_data in  DATA_WIDTH  FIFO data, valid the cycle after rd_en    |
// |   fifo_rd_val  in  1           FIFO read-valid, sampled only in WAIT     |
// |   tx_out       out 1           serial line, idles high                   |
// |   tx_busy      out 1           high from frame load to end of stop bit   |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_serial_tx
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = c_fifo_data_width,
   parameter int CLKS_PER_BIT = 4,
   parameter int POLL_GAP     = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tx_en,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_val,
   output logic                  tx_out,
   output logic                  tx_busy
);

   localparam int                 c_idx_w    = $clog2(DATA_WIDTH + 1);
   localparam int                 c_gap_w    = $clog2(POLL_GAP + 1);
   localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(DATA_WIDTH - 1);
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(POLL_GAP - 1);

   fifo_state_t           r_state;
   logic                  r_rd_en;
   logic                  r_tx_out;
   logic                  r_tx_busy;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [c_idx_w-1:0]    r_bit_idx;
   logic [c_gap_w-1:0]    r_gap_cnt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic                  r_parity;
`endif

   logic                  w_timer_load;
   logic                  w_timer_en;
   logic                  w_tick;
   logic [DATA_WIDTH-1:0] w_shift_next;

   // The timer is started when a word is accepted, so it is already
   // counting on the first START cycle; it then free-runs through the frame.
   always_comb begin
      w_timer_load = 1'b0;
      w_timer_en   = 1'b0;
      if (r_state == c_st_wait) begin
         w_timer_load = fifo_rd_val;
      end
      if ((r_state == c_st_start) || (r_state == c_st_data) ||
          (r_state == c_st_parity) || (r_state == c_st_stop)) begin
         w_timer_en = 1'b1;
      end
   end

   assign w_shift_next = r_shift >> 1;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (w_timer_load),
      .enable  (w_timer_en),
      .tick    (w_tick)
   );

   // Every output is a register; tx_out is updated one clock ahead of the
   // state it belongs to so the line changes exactly on the bit boundary.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_st_idle;
         r_rd_en   <= 1'b0;
         r_tx_out  <= 1'b1;
         r_tx_busy <= 1'b0;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_gap_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         case (r_state)
            c_st_idle: begin
               if (tx_en) begin
                  r_rd_en <= 1'b1;
                  r_state <= c_st_req;
               end
            end
            c_st_req: begin
               r_rd_en <= 1'b0;
               r_state <= c_st_wait;
            end
            c_st_wait: begin
               if (fifo_rd_val) begin
                  r_shift   <= fifo_rd_data;
                  r_bit_idx <= '0;
                  r_tx_busy <= 1'b1;
                  r_tx_out  <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                  r_parity  <= ^fifo_rd_data;
`endif
                  r_state   <= c_st_start;
               end else begin
                  r_gap_cnt <= '0;
                  r_state   <= c_st_gap;
               end
            end
            c_st_gap: begin
               if (r_gap_cnt == c_gap_last) begin
                  r_gap_cnt <= '0;
                  r_state   <= c_st_idle;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            c_st_start: begin
               if (w_tick) begin
                  r_tx_out <= r_shift[0];
                  r_state  <= c_st_data;
               end
            end
            c_st_data: begin
               if (w_tick) begin
                  if (r_bit_idx == c_last_bit) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                     r_tx_out <= r_parity;
                     r_state  <= c_st_parity;
`else
                     r_tx_out <= 1'b1;
                     r_state  <= c_st_stop;
`endif
                  end else begin
                     r_shift   <= w_shift_next;
                     r_tx_out  <= w_shift_next[0];
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            c_st_parity: begin
               if (w_tick) begin
                  r_tx_out <= 1'b1;
                  r_state  <= c_st_stop;
               end
            end
`endif
            c_st_stop: begin
               if (w_tick) begin
                  r_tx_busy <= 1'b0;
                  r_state   <= c_st_idle;
               end
            end
            default: begin
               r_rd_en   <= 1'b0;
               r_tx_out  <= 1'b1;
               r_tx_busy <= 1'b0;
               r_state   <= c_st_idle;
            end
         endcase
      end
   end

   assign fifo_rd_en = r_rd_en;
   assign tx_out     = r_tx_out;
   assign tx_busy    = r_tx_busy;

endmodule : fifo_serial_tx

`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_serial_tx                                          |
// | Description : Self-checking bench for fifo_serial_tx. A queue-based FIFO |
// |               model answers reads and records every word handed out; a   |
// |               line monitor decodes frames from tx_out and compares them  |
// |               against those recorded words. Honours                      |
// |               FIFO_SERIAL_TX_PARITY_EN for the expected frame format.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_serial_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int GAP = 2;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int c_par = 1;
`else
   localparam int c_par = 0;
`endif
   localparam int c_nbits = DW + 2 + c_par;
   localparam int c_ncyc  = c_nbits * CPB;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          tx_en;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_val;
   logic          tx_out;
   logic          tx_busy;

   always #5 clk = ~clk;

   fifo_serial_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .POLL_GAP     (GAP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tx_en        (tx_en),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_val  (fifo_rd_val),
      .tx_out       (tx_out),
      .tx_busy      (tx_busy)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            busy_run = 0;
   bit            rand_empty = 1'b0;
   bit            in_frame   = 1'b0;
   bit            pending    = 1'b0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            rden_cyc[$];
   int            fstart_cyc[$];
   int            fend_cyc[$];
   int            busy_len[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input string name, input int bound);
      bit done = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !in_frame && !tx_busy) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, int'(done), 1);
   endtask

   // Cycle counter; everything else samples #1 after the edge.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Read-pulse log and busy-run lengths.
   initial forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
         busy_run = 0;
      end else begin
         if (fifo_rd_en) rden_cyc.push_back(cyc);
         if (tx_busy) begin
            busy_run++;
         end else if (busy_run > 0) begin
            busy_len.push_back(busy_run);
            busy_run = 0;
         end
      end
   end

   // FIFO model: answers the cycle after a read pulse; drives noise otherwise.
   initial begin
      logic [DW-1:0] w;
      fifo_rd_val  = 1'b0;
      fifo_rd_data = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pending     = 1'b0;
            fifo_rd_val = 1'b0;
         end else begin
            if (pending) begin
               if (fifo_q.size() > 0 && !(rand_empty && $urandom_range(0, 3) == 0)) begin
                  w            = fifo_q.pop_front();
                  fifo_rd_val  = 1'b1;
                  fifo_rd_data = w;
                  exp_q.push_back(w);
               end else begin
                  fifo_rd_val  = 1'b0;
                  fifo_rd_data = DW'($urandom);
               end
            end else begin
               fifo_rd_val  = 1'($urandom_range(0, 1));
               fifo_rd_data = DW'($urandom);
            end
            pending = fifo_rd_en;
         end
      end
   end

   // Line monitor: captures one full frame from the falling start edge.
   initial begin : monitor
      logic          samp [c_ncyc];
      logic [DW-1:0] word;
      logic [DW-1:0] ex;
      logic          prev_busy;
      int            busy_bad;
      int            rden_bad;
      int            shape_bad;
      bit            aborted;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            prev_busy = 1'b0;
            continue;
         end
         if (tx_out !== 1'b0) begin
            prev_busy = tx_busy;
            continue;
         end
         in_frame = 1'b1;
         fstart_cyc.push_back(cyc);
         samp[0]  = tx_out;
         busy_bad = int'(prev_busy !== 1'b0) + int'(tx_busy !== 1'b1);
         rden_bad = int'(fifo_rd_en !== 1'b0);
         aborted  = 1'b0;
         for (int i = 1; i < c_ncyc; i++) begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
               aborted = 1'b1;
               break;
            end
            samp[i] = tx_out;
            if (tx_busy !== 1'b1) busy_bad++;
            if (fifo_rd_en !== 1'b0) rden_bad++;
         end
         if (aborted) begin
            in_frame  = 1'b0;
            prev_busy = 1'b0;
            continue;
         end
         fend_cyc.push_back(cyc);
         shape_bad = 0;
         for (int b = 0; b < c_nbits; b++)
            for (int j = 1; j < CPB; j++)
               if (samp[b*CPB+j] !== samp[b*CPB]) shape_bad++;
         if (samp[(c_nbits-1)*CPB] !== 1'b1) shape_bad++;
         for (int k = 0; k < DW; k++) word[k] = samp[(1+k)*CPB];
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(word), -1);
         end else begin
            ex = exp_q.pop_front();
            chk("frame_data", int'(word), int'(ex));
`ifdef FIFO_SERIAL_TX_PARITY_EN
            chk("parity_bit", int'(samp[(1+DW)*CPB]), int'(^ex));
`endif
         end
         chk("frame_shape", shape_bad, 0);
         chk("frame_busy", busy_bad, 0);
         chk("frame_no_read", rden_bad, 0);
         @(posedge clk);
         #1;
         if (reset_n) chk("post_frame_idle", int'({tx_busy, tx_out}), 1);
         prev_busy = tx_busy;
         in_frame  = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int nxt;
      int s;
      bit seen;
      reset_n = 1'b0;
      tx_en   = 1'b1;

      // Reset held with tx_en high: line idle, no reads.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("reset_state", int'({tx_out, tx_busy, fifo_rd_en}), 4);
      end
      tx_en = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_cycles(4);
      chk("idle_no_read", rden_cyc.size(), 0);

      // Single word 0xA5.
      busy_len.delete();
      fifo_q.push_back(8'hA5);
      tx_en = 1'b1;
      wait_drain("a5_drain", 200);
      tx_en = 1'b0;
      wait_cycles(8);
      chk("a5_busy_len", (busy_len.size() > 0) ? busy_len[0] : -1, c_ncyc);

      // Empty FIFO: periodic polling, line stays idle.
      rden_cyc.delete();
      tx_en = 1'b1;
      bad   = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      tx_en = 1'b0;
      wait_cycles(8);
      chk("empty_line_idle", bad, 0);
      chk("empty_poll_count", int'(rden_cyc.size() >= 5), 1);
      bad = 0;
      for (int i = 1; i < rden_cyc.size(); i++)
         if (rden_cyc[i] - rden_cyc[i-1] != GAP + 3) bad++;
      chk("empty_poll_period", bad, 0);

      // Back-to-back 0x00 then 0xFF.
      fstart_cyc.delete();
      fend_cyc.delete();
      rden_cyc.delete();
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'hFF);
      tx_en = 1'b1;
      wait_drain("b2b_drain", 400);
      tx_en = 1'b0;
      wait_cycles(8);
      chk("b2b_frames", fend_cyc.size(), 2);
      if (fend_cyc.size() >= 1 && fstart_cyc.size() >= 2) begin
         chk("b2b_idle_gap", fstart_cyc[1] - fend_cyc[0], 4);
         nxt = -1;
         foreach (rden_cyc[i])
            if (nxt < 0 && rden_cyc[i] > fend_cyc[0]) nxt = rden_cyc[i];
         chk("b2b_next_read", nxt - fend_cyc[0], 2);
      end

      // Word 0x07: frame length with/without parity.
      busy_len.delete();
      fifo_q.push_back(8'h07);
      tx_en = 1'b1;
      wait_drain("w07_drain", 200);
      tx_en = 1'b0;
      wait_cycles(8);
      chk("w07_busy_len", (busy_len.size() > 0) ? busy_len[0] : -1, c_ncyc);

      // Random words, random empties and random tx_en toggling.
      rand_empty = 1'b1;
      for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
      seen = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) tx_en = ~tx_en;
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !in_frame && !tx_busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk("random_drain", int'(seen), 1);
      tx_en      = 1'b0;
      rand_empty = 1'b0;
      wait_cycles(8);

      // Asynchronous reset during data bit 3.
      fstart_cyc.delete();
      fifo_q.push_back(8'h3C);
      tx_en = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (fstart_cyc.size() > 0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("abort_frame_started", int'(seen), 1);
      if (seen) begin
         s = fstart_cyc[0];
         for (int i = 0; i < 40 && cyc != s + 4 + 3*CPB + 1; i++) begin
            @(posedge clk);
            #1;
         end
         #3;
         reset_n = 1'b0;
         #1;
         chk("abort_line", int'({tx_out, tx_busy, fifo_rd_en}), 4);
         exp_q.delete();
         fifo_q.delete();
         bad = 0;
         repeat (5) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx_out !== 1'b1) bad++;
         end
         chk("abort_held_quiet", bad, 0);
         tx_en = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
         rden_cyc.delete();
         wait_cycles(6);
         chk("abort_no_read_when_disabled", rden_cyc.size(), 0);
         tx_en = 1'b1;
         wait_cycles(6);
         chk("abort_resume_read", int'(rden_cyc.size() > 0), 1);
         tx_en = 1'b0;
         wait_cycles(10);
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fifo_serial_tx

`default_nettype wire
